// File: rtl/dram_port_arbiter_pkg.sv
// Shared definitions for the DRAM client-port arbiter: request word layout,
// client identifiers and the address-width derivation also used by the controller.
package dram_port_arbiter_pkg;

  localparam logic REQ_WR = 1'b1;
  localparam logic REQ_RD = 1'b0;

  typedef enum logic {
    CLIENT0 = 1'b0,
    CLIENT1 = 1'b1
  } client_e;

  // Page address width: DRAM bits divided by page width, in log2 form.
  function automatic int addr_size(input int log_dram_size, input int page_len);
    return log_dram_size - $clog2(page_len);
  endfunction

  // Request word is {wr, page_addr}; the write flag sits just above the address.
  function automatic int req_size(input int log_addr_size);
    return 1 + log_addr_size;
  endfunction

  function automatic int req_wr_bit(input int log_addr_size);
    return log_addr_size;
  endfunction

endpackage

// File: rtl/dram_tag_fifo.sv
// In-order tag FIFO holding the client id of every outstanding read.
// Count-based full/empty; push while full and pop while empty are ignored.
module dram_tag_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one page-based DRAM controller between two clients,
// with an in-order tag FIFO steering returned read pages back to their issuer.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int  LOG_DRAM_SIZE = 6,
  parameter int  PAGE_LEN      = 32,
  parameter int  TAG_DEPTH     = 8,
  localparam int LOG_ADDR_SIZE = addr_size(LOG_DRAM_SIZE, PAGE_LEN),
  localparam int LOG_REQ_SIZE  = req_size(LOG_ADDR_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  // client 0
  input  logic                     c0_req_valid,
  output logic                     c0_req_ready,
  input  logic                     c0_req_wr,
  input  logic [LOG_ADDR_SIZE-1:0] c0_req_addr,
  input  logic [PAGE_LEN-1:0]      c0_wdata,
  input  logic                     c0_rdata_ready,
  output logic                     c0_rdata_valid,
  output logic [PAGE_LEN-1:0]      c0_rdata,
  // client 1
  input  logic                     c1_req_valid,
  output logic                     c1_req_ready,
  input  logic                     c1_req_wr,
  input  logic [LOG_ADDR_SIZE-1:0] c1_req_addr,
  input  logic [PAGE_LEN-1:0]      c1_wdata,
  input  logic                     c1_rdata_ready,
  output logic                     c1_rdata_valid,
  output logic [PAGE_LEN-1:0]      c1_rdata,
  // controller FIFOs
  output logic                     frq_write_en,
  output logic [LOG_REQ_SIZE-1:0]  frq_write_data,
  input  logic                     frq_full,
  output logic                     fin_write_en,
  output logic [PAGE_LEN-1:0]      fin_write_data,
  input  logic                     fin_full,
  output logic                     fout_read_en,
  input  logic [PAGE_LEN-1:0]      fout_read_data,
  input  logic                     fout_empty
);

  localparam int REQ_WR_BIT = req_wr_bit(LOG_ADDR_SIZE);

  logic [1:0]               req_valid;
  logic [1:0]               req_wr;
  logic [1:0]               rdata_ready;
  logic [LOG_ADDR_SIZE-1:0] req_addr [2];
  logic [PAGE_LEN-1:0]      wdata    [2];

  logic [1:0]               eligible;
  logic [1:0]               grant;
  logic                     any_grant;
  logic                     gnt_idx;
  logic                     gnt_is_wr;
  client_e                  last_grant;

  logic                     tag_push;
  logic                     tag_pop;
  logic                     tag_head;
  logic                     tag_full;
  logic                     tag_empty;

  logic [1:0]               rdata_valid_q;
  logic [PAGE_LEN-1:0]      rdata_q [2];

  assign req_valid   = {c1_req_valid, c0_req_valid};
  assign req_wr      = {c1_req_wr, c0_req_wr};
  assign rdata_ready = {c1_rdata_ready, c0_rdata_ready};
  assign req_addr[0] = c0_req_addr;
  assign req_addr[1] = c1_req_addr;
  assign wdata[0]    = c0_wdata;
  assign wdata[1]    = c1_wdata;

  // A client only competes if every FIFO its request touches has room, so a
  // stalled writer never blocks a reader on the other port.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      eligible[i] = !rst && req_valid[i] && !frq_full &&
                    (req_wr[i] ? !fin_full : !tag_full);
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == CLIENT1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign any_grant    = |grant;
  assign gnt_idx      = grant[1];
  assign gnt_is_wr    = req_wr[gnt_idx];
  assign c0_req_ready = grant[0];
  assign c1_req_ready = grant[1];

  // Write grants push both controller FIFOs together; reads push only the request word.
  always_comb begin
    frq_write_en   = 1'b0;
    frq_write_data = '0;
    fin_write_en   = 1'b0;
    fin_write_data = '0;
    tag_push       = 1'b0;
    if (any_grant) begin
      frq_write_en                       = 1'b1;
      frq_write_data[LOG_ADDR_SIZE-1:0]  = req_addr[gnt_idx];
      frq_write_data[REQ_WR_BIT]         = gnt_is_wr ? REQ_WR : REQ_RD;
      if (gnt_is_wr) begin
        fin_write_en   = 1'b1;
        fin_write_data = wdata[gnt_idx];
      end else begin
        tag_push = 1'b1;
      end
    end
  end

  // Return path: the oldest read's owner must be ready; otherwise the page waits.
  assign tag_pop      = !rst && !tag_empty && !fout_empty && rdata_ready[tag_head];
  assign fout_read_en = tag_pop;

  dram_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (gnt_idx),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant    <= CLIENT1;
      rdata_valid_q <= 2'b00;
      rdata_q[0]    <= '0;
      rdata_q[1]    <= '0;
    end else begin
      if (any_grant) begin
        last_grant <= client_e'(gnt_idx);
      end
      rdata_valid_q <= 2'b00;
      if (tag_pop) begin
        rdata_valid_q[tag_head] <= 1'b1;
        rdata_q[tag_head]       <= fout_read_data;
      end
    end
  end

  assign c0_rdata_valid = rdata_valid_q[0];
  assign c1_rdata_valid = rdata_valid_q[1];
  assign c0_rdata       = rdata_q[0];
  assign c1_rdata       = rdata_q[1];

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: stimulus queues expected grants, FIFO
// pushes and returned pages; a negedge monitor compares whatever the DUT presents.
module tb_dram_port_arbiter;

  localparam int AW = 1;
  localparam int RW = 2;
  localparam int PL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c0_req_valid, c0_req_ready, c0_req_wr, c0_rdata_ready, c0_rdata_valid;
  logic [AW-1:0] c0_req_addr;
  logic [PL-1:0] c0_wdata, c0_rdata;
  logic          c1_req_valid, c1_req_ready, c1_req_wr, c1_rdata_ready, c1_rdata_valid;
  logic [AW-1:0] c1_req_addr;
  logic [PL-1:0] c1_wdata, c1_rdata;
  logic          frq_write_en, frq_full, fin_write_en, fin_full;
  logic [RW-1:0] frq_write_data;
  logic [PL-1:0] fin_write_data;
  logic          fout_read_en, fout_empty;
  logic [PL-1:0] fout_read_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0]    exp_gnt [$];
  logic [RW-1:0] exp_frq [$];
  logic [PL-1:0] exp_fin [$];
  logic [PL-1:0] exp_rd0 [$];
  logic [PL-1:0] exp_rd1 [$];
  logic [PL-1:0] fout_q  [$];
  logic          fout_arm = 1'b0;

  always #5 clk = ~clk;

  dram_port_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .c0_req_valid   (c0_req_valid),
    .c0_req_ready   (c0_req_ready),
    .c0_req_wr      (c0_req_wr),
    .c0_req_addr    (c0_req_addr),
    .c0_wdata       (c0_wdata),
    .c0_rdata_ready (c0_rdata_ready),
    .c0_rdata_valid (c0_rdata_valid),
    .c0_rdata       (c0_rdata),
    .c1_req_valid   (c1_req_valid),
    .c1_req_ready   (c1_req_ready),
    .c1_req_wr      (c1_req_wr),
    .c1_req_addr    (c1_req_addr),
    .c1_wdata       (c1_wdata),
    .c1_rdata_ready (c1_rdata_ready),
    .c1_rdata_valid (c1_rdata_valid),
    .c1_rdata       (c1_rdata),
    .frq_write_en   (frq_write_en),
    .frq_write_data (frq_write_data),
    .frq_full       (frq_full),
    .fin_write_en   (fin_write_en),
    .fin_write_data (fin_write_data),
    .fin_full       (fin_full),
    .fout_read_en   (fout_read_en),
    .fout_read_data (fout_read_data),
    .fout_empty     (fout_empty)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Model of the controller's first-word-fall-through output FIFO.
  task automatic fout_refresh();
    fout_empty     = (fout_q.size() == 0);
    fout_read_data = (fout_q.size() != 0) ? fout_q[0] : '0;
  endtask

  task automatic fout_push(input logic [PL-1:0] page);
    fout_q.push_back(page);
    fout_refresh();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_gnt.size() + exp_frq.size() + exp_fin.size() +
          exp_rd0.size() + exp_rd1.size() + fout_q.size() == 0) break;
      step();
    end
    check(name, 64'(exp_gnt.size() + exp_frq.size() + exp_fin.size() +
                    exp_rd0.size() + exp_rd1.size() + fout_q.size()), 64'd0);
  endtask

  task automatic expect_grant(input logic [1:0] g, input logic [RW-1:0] word);
    exp_gnt.push_back(g);
    exp_frq.push_back(word);
  endtask

  // Monitor: compares every presented event against the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      fout_arm = fout_read_en;
      if (c0_req_ready || c1_req_ready) begin
        if (exp_gnt.size() == 0) check("grant_unexpected", {c1_req_ready, c0_req_ready}, 2'b00);
        else check("grant", {c1_req_ready, c0_req_ready}, exp_gnt.pop_front());
      end
      if (frq_write_en) begin
        if (exp_frq.size() == 0) check("frq_unexpected", frq_write_data, '1);
        else check("frq_word", frq_write_data, exp_frq.pop_front());
      end
      if (fin_write_en) begin
        check("fin_paired_with_frq_write", {frq_write_en, frq_write_data[AW]}, 2'b11);
        if (exp_fin.size() == 0) check("fin_unexpected", fin_write_data, '1);
        else check("fin_data", fin_write_data, exp_fin.pop_front());
      end
      if (c0_rdata_valid) begin
        if (exp_rd0.size() == 0) check("c0_rdata_unexpected", c0_rdata, '1);
        else check("c0_rdata", c0_rdata, exp_rd0.pop_front());
      end
      if (c1_rdata_valid) begin
        if (exp_rd1.size() == 0) check("c1_rdata_unexpected", c1_rdata, '1);
        else check("c1_rdata", c1_rdata, exp_rd1.pop_front());
      end
    end
  end

  // Output FIFO pops take effect just after the edge that consumed the head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (fout_arm) begin
        if (fout_q.size() != 0) void'(fout_q.pop_front());
        fout_arm = 1'b0;
        fout_refresh();
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    {c0_req_valid, c0_req_wr, c1_req_valid, c1_req_wr} = '0;
    c0_req_addr = '0; c1_req_addr = '0; c0_wdata = '0; c1_wdata = '0;
    c0_rdata_ready = 1'b1; c1_rdata_ready = 1'b1;
    frq_full = 1'b0; fin_full = 1'b0;
    fout_refresh();
    step(); step();
    neg();
    check("reset_ctrl_outputs", {c0_req_ready, c1_req_ready, c0_rdata_valid, c1_rdata_valid,
                                 frq_write_en, fin_write_en, fout_read_en}, 7'd0);
    check("reset_data_outputs", {frq_write_data, c0_rdata[15:0], c1_rdata[15:0]}, '0);
    check("reset_fin_data", fin_write_data, '0);
    step(); rst = 1'b0;

    // Both clients read every cycle: c0 wins the first tie, then strict alternation.
    step(); c0_req_valid = 1; c0_req_addr = 0; c1_req_valid = 1; c1_req_addr = 1;
    expect_grant(2'b01, 2'b00);
    step(); c0_req_addr = 1;
    expect_grant(2'b10, 2'b01);
    step(); c1_req_addr = 0;
    expect_grant(2'b01, 2'b01);
    step();
    expect_grant(2'b10, 2'b00);
    step(); c0_req_valid = 0; c1_req_valid = 0;
    fout_push(32'hA000_0000); exp_rd0.push_back(32'hA000_0000);
    fout_push(32'hA000_0001); exp_rd1.push_back(32'hA000_0001);
    fout_push(32'hA000_0002); exp_rd0.push_back(32'hA000_0002);
    fout_push(32'hA000_0003); exp_rd1.push_back(32'hA000_0003);
    drain("drain_rr_reads");

    // Write pushes both FIFOs; no tag is created, so a stray page is not popped.
    step(); c0_req_valid = 1; c0_req_wr = 1; c0_req_addr = 1; c0_wdata = 32'hDEAD_BEEF;
    expect_grant(2'b01, 2'b11); exp_fin.push_back(32'hDEAD_BEEF);
    step(); c0_req_valid = 0; c0_req_wr = 0;
    fout_push(32'h5555_AAAA);
    neg(); check("no_pop_tag_empty_0", fout_read_en, 1'b0);
    step();
    neg(); check("no_pop_tag_empty_1", fout_read_en, 1'b0);
    step(); c1_req_valid = 1; c1_req_addr = 0;
    expect_grant(2'b10, 2'b00); exp_rd1.push_back(32'h5555_AAAA);
    neg(); check("no_push_through", fout_read_en, 1'b0);
    step(); c1_req_valid = 0;
    drain("drain_write_stray");

    // fin_full stalls the c0 write only; c1 read proceeds. frq_full blocks everyone.
    step(); fin_full = 1;
    c0_req_valid = 1; c0_req_wr = 1; c0_req_addr = 0; c0_wdata = 32'h1234_5678;
    c1_req_valid = 1; c1_req_wr = 0; c1_req_addr = 1;
    expect_grant(2'b10, 2'b01);
    step(); c1_req_valid = 0;
    neg(); check("fin_full_stall_0", c0_req_ready, 1'b0);
    step();
    neg(); check("fin_full_stall_1", c0_req_ready, 1'b0);
    step(); fin_full = 0; frq_full = 1; c1_req_valid = 1;
    neg(); check("frq_full_blocks", {c1_req_ready, c0_req_ready}, 2'b00);
    step(); frq_full = 0; c1_req_valid = 0;
    expect_grant(2'b01, 2'b10); exp_fin.push_back(32'h1234_5678);
    step(); c0_req_valid = 0; c0_req_wr = 0;
    fout_push(32'hC1C1_0001); exp_rd1.push_back(32'hC1C1_0001);
    drain("drain_fin_full");

    // Nine reads with no data back: eight accepted, ninth held until a pop frees a slot.
    for (int i = 0; i < 8; i++) begin
      step(); c0_req_valid = 1; c0_req_addr = AW'(i % 2);
      expect_grant(2'b01, {1'b0, AW'(i % 2)});
    end
    step(); c0_req_addr = 0;
    neg(); check("tag_full_hold_0", c0_req_ready, 1'b0);
    step();
    neg(); check("tag_full_hold_1", c0_req_ready, 1'b0);
    step(); fout_push(32'hB000_0000); exp_rd0.push_back(32'hB000_0000);
    neg(); check("pop_at_full", fout_read_en, 1'b1);
    check("no_push_on_pop_at_full", c0_req_ready, 1'b0);
    step(); expect_grant(2'b01, 2'b00);
    step(); c0_req_valid = 0;
    for (int i = 1; i <= 8; i++) begin
      fout_push(32'hB000_0000 + 32'(i)); exp_rd0.push_back(32'hB000_0000 + 32'(i));
    end
    drain("drain_tag_full");

    // Head client not ready stalls the other client's page too.
    step(); c0_req_valid = 1; c0_req_addr = 1;
    expect_grant(2'b01, 2'b01);
    step(); c0_req_valid = 0; c1_req_valid = 1; c1_req_addr = 0;
    expect_grant(2'b10, 2'b00);
    step(); c1_req_valid = 0; c0_rdata_ready = 0;
    fout_push(32'h0000_00F0); exp_rd0.push_back(32'h0000_00F0);
    fout_push(32'h0000_00F1); exp_rd1.push_back(32'h0000_00F1);
    neg(); check("head_stall_0", fout_read_en, 1'b0);
    step();
    neg(); check("head_stall_1", fout_read_en, 1'b0);
    step();
    neg(); check("head_stall_2", fout_read_en, 1'b0);
    step(); c0_rdata_ready = 1;
    neg(); check("head_release", fout_read_en, 1'b1);
    drain("drain_in_order");
    step();
    neg(); check("rdata_hold", {c0_rdata_valid, c0_rdata}, {1'b0, 32'h0000_00F0});

    // Reset with three reads outstanding.
    step(); c0_req_valid = 1; c0_req_addr = 0;
    expect_grant(2'b01, 2'b00);
    step(); c0_req_valid = 0; c1_req_valid = 1; c1_req_addr = 1;
    expect_grant(2'b10, 2'b01);
    step(); c1_req_valid = 0; c0_req_valid = 1; c0_req_addr = 1;
    expect_grant(2'b01, 2'b01);
    step(); c0_req_valid = 0; rst = 1;
    step();
    neg();
    check("midrst_ctrl_outputs", {c0_req_ready, c1_req_ready, c0_rdata_valid, c1_rdata_valid,
                                  frq_write_en, fin_write_en, fout_read_en}, 7'd0);
    check("midrst_rdata_cleared", {c0_rdata, c1_rdata}, 64'd0);
    step(); rst = 0;
    fout_push(32'hE000_0000);
    neg(); check("tag_empty_after_rst", fout_read_en, 1'b0);
    step(); c0_req_valid = 1; c0_req_addr = 0; c1_req_valid = 1; c1_req_addr = 1;
    expect_grant(2'b01, 2'b00); exp_rd0.push_back(32'hE000_0000);
    step(); c0_req_valid = 0;
    expect_grant(2'b10, 2'b01);
    step(); c1_req_valid = 0;
    fout_push(32'hE000_0001); exp_rd1.push_back(32'hE000_0001);
    drain("drain_after_rst");

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
